// File: rtl/ps2_note_scheduler.sv
// ps2_note_scheduler: PS/2 byte stream to single-voice note/gate control with last-pressed priority
module ps2_note_scheduler #(
    parameter bit RELEASE_FALLBACK = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data,
    output logic [3:0]  note,
    output logic        note_in,
    output logic        note_trig,
    output logic        octave_minus_minus,
    output logic        octave_plus_plus,
    output logic        sustain,
    output logic [11:0] held_mask
);
    localparam logic [1:0] IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3;
    logic [1:0]  st;
    logic        oct_dn_held, oct_up_held, sus_held;
    logic        key_hit, is_make, is_brk;
    logic [3:0]  key_idx, low_idx;
    logic [11:0] rest_mask;
    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case (ps2_key_data)
            8'h1C: key_idx = 4'd0;
            8'h1D: key_idx = 4'd1;
            8'h1B: key_idx = 4'd2;
            8'h24: key_idx = 4'd3;
            8'h23: key_idx = 4'd4;
            8'h2B: key_idx = 4'd5;
            8'h2C: key_idx = 4'd6;
            8'h34: key_idx = 4'd7;
            8'h35: key_idx = 4'd8;
            8'h33: key_idx = 4'd9;
            8'h3C: key_idx = 4'd10;
            8'h3B: key_idx = 4'd11;
            default: key_hit = 1'b0;
        endcase
    end
    assign rest_mask = held_mask & ~(12'd1 << key_idx);
    // Fallback target: lowest still-held key once this one is released
    always_comb begin
        low_idx = 4'd0;
        for (int i = 11; i >= 0; i--)
            if (rest_mask[i]) low_idx = 4'(i);
    end
    assign is_make = ps2_key_pressed && st == IDLE && ps2_key_data != 8'hF0 && ps2_key_data != 8'hE0;
    assign is_brk  = ps2_key_pressed && st == BRK;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st                 <= IDLE;
            note               <= 4'd0;
            note_in            <= 1'b0;
            note_trig          <= 1'b0;
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            sustain            <= 1'b0;
            held_mask          <= 12'd0;
            oct_dn_held        <= 1'b0;
            oct_up_held        <= 1'b0;
            sus_held           <= 1'b0;
        end else begin
            note_trig          <= 1'b0;
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            if (ps2_key_pressed)
                case (st)
                    IDLE:    st <= (ps2_key_data == 8'hF0) ? BRK : (ps2_key_data == 8'hE0) ? EXT : IDLE;
                    EXT:     st <= (ps2_key_data == 8'hF0) ? EXT_BRK : IDLE;
                    default: st <= IDLE;
                endcase
            if (is_make) begin
                if (key_hit && !held_mask[key_idx]) begin
                    held_mask[key_idx] <= 1'b1;
                    note               <= key_idx;
                    note_in            <= 1'b1;
                    note_trig          <= 1'b1;
                end
                case (ps2_key_data)
                    8'h1A: begin
                        octave_minus_minus <= !oct_dn_held;
                        oct_dn_held        <= 1'b1;
                    end
                    8'h22: begin
                        octave_plus_plus <= !oct_up_held;
                        oct_up_held      <= 1'b1;
                    end
                    8'h0D: begin
                        sus_held <= 1'b1;
                        if (!sus_held) begin
                            sustain <= !sustain;
                            if (sustain && held_mask == 12'd0) note_in <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (is_brk) begin
                if (key_hit) begin
                    held_mask <= rest_mask;
                    if (key_idx == note) begin
                        if (RELEASE_FALLBACK && rest_mask != 12'd0) note <= low_idx;
                        else note_in <= sustain;
                    end
                end
                case (ps2_key_data)
                    8'h1A:   oct_dn_held <= 1'b0;
                    8'h22:   oct_up_held <= 1'b0;
                    8'h0D:   sus_held    <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_note_scheduler.sv
// tb_ps2_note_scheduler: directed table, hand sequences and random stimulus against a behavioural model
module tb_ps2_note_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_key_data = 8'h00;
    logic [3:0]  note_o [2];
    logic        gate_o [2], trig_o [2], dn_o [2], up_o [2], sus_o [2];
    logic [11:0] mask_o [2];
    int checks = 0, errors = 0, up_cnt = 0;
    always #5 clk = ~clk;
    ps2_note_scheduler #(.RELEASE_FALLBACK(1'b0)) u0 (
        .CLOCK_50(clk), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
        .note(note_o[0]), .note_in(gate_o[0]), .note_trig(trig_o[0]), .octave_minus_minus(dn_o[0]),
        .octave_plus_plus(up_o[0]), .sustain(sus_o[0]), .held_mask(mask_o[0]));
    ps2_note_scheduler #(.RELEASE_FALLBACK(1'b1)) u1 (
        .CLOCK_50(clk), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
        .note(note_o[1]), .note_in(gate_o[1]), .note_trig(trig_o[1]), .octave_minus_minus(dn_o[1]),
        .octave_plus_plus(up_o[1]), .sustain(sus_o[1]), .held_mask(mask_o[1]));
    typedef struct packed {
        logic [3:0]  note;
        logic        gate, trig, dn, up, sus;
        logic [11:0] mask;
        logic        brk, ext, dnh, uph, sush;
    } model_t;
    typedef struct packed {
        logic        stb;
        logic [7:0]  d;
        logic [3:0]  note;
        logic        gate, trig;
        logic [11:0] mask;
    } vec_t;
    model_t m [2];
    vec_t   tbl [16];
    logic [7:0] codes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [7:0] pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B,
                              8'h1A, 8'h22, 8'h0D, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h5A};
    function automatic int key_of(logic [7:0] d);
        for (int i = 0; i < 12; i++) if (codes[i] == d) return i;
        return -1;
    endfunction
    function automatic model_t step(model_t s, logic stb, logic [7:0] d, bit fb);
        model_t n = s;
        int k = key_of(d);
        n.trig = 0; n.dn = 0; n.up = 0;
        if (!stb) return n;
        if (s.ext) begin
            n.ext = (!s.brk && d == 8'hF0);
            n.brk = n.ext;
            return n;
        end
        if (s.brk) begin
            n.brk = 0;
            if (k >= 0) begin
                n.mask[k] = 1'b0;
                if (k == int'(s.note)) begin
                    if (fb && n.mask != 0) begin
                        for (int i = 11; i >= 0; i--) if (n.mask[i]) n.note = 4'(i);
                    end else n.gate = s.sus;
                end
            end
            if (d == 8'h1A) n.dnh = 0;
            if (d == 8'h22) n.uph = 0;
            if (d == 8'h0D) n.sush = 0;
            return n;
        end
        if (d == 8'hF0) begin n.brk = 1; return n; end
        if (d == 8'hE0) begin n.ext = 1; return n; end
        if (k >= 0 && !s.mask[k]) begin
            n.mask[k] = 1'b1; n.note = 4'(k); n.gate = 1; n.trig = 1;
        end
        if (d == 8'h1A) begin n.dn = !s.dnh; n.dnh = 1; end
        if (d == 8'h22) begin n.up = !s.uph; n.uph = 1; end
        if (d == 8'h0D) begin
            if (!s.sush) begin
                n.sus = !s.sus;
                if (s.sus && s.mask == 0) n.gate = 0;
            end
            n.sush = 1;
        end
        return n;
    endfunction
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d note", k), note_o[k], m[k].note);
            chk($sformatf("u%0d note_in", k), gate_o[k], m[k].gate);
            chk($sformatf("u%0d note_trig", k), trig_o[k], m[k].trig);
            chk($sformatf("u%0d oct_dn", k), dn_o[k], m[k].dn);
            chk($sformatf("u%0d oct_up", k), up_o[k], m[k].up);
            chk($sformatf("u%0d sustain", k), sus_o[k], m[k].sus);
            chk($sformatf("u%0d held_mask", k), mask_o[k], m[k].mask);
        end
    endtask
    task automatic cycle(logic stb, logic [7:0] d);
        @(negedge clk);
        ps2_key_pressed = stb;
        ps2_key_data = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) m[k] = step(m[k], stb, d, k == 1);
        up_cnt += int'(up_o[1]);
        chk_model();
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ps2_key_pressed = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m[0] = '0;
        m[1] = '0;
    endtask
    task automatic chk_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d outputs", tag, k),
                {note_o[k], gate_o[k], trig_o[k], dn_o[k], up_o[k], sus_o[k], mask_o[k]}, 0);
        end
    endtask
    initial begin
        tbl[0]  = '{1'b1, 8'h1C, 4'd0,  1'b1, 1'b1, 12'h001};
        tbl[1]  = '{1'b1, 8'hF0, 4'd0,  1'b1, 1'b0, 12'h001};
        tbl[2]  = '{1'b1, 8'h1C, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[3]  = '{1'b1, 8'h1C, 4'd0,  1'b1, 1'b1, 12'h001};
        tbl[4]  = '{1'b1, 8'h3B, 4'd11, 1'b1, 1'b1, 12'h801};
        tbl[5]  = '{1'b1, 8'hF0, 4'd11, 1'b1, 1'b0, 12'h801};
        tbl[6]  = '{1'b1, 8'h3B, 4'd0,  1'b1, 1'b0, 12'h001};
        tbl[7]  = '{1'b1, 8'hF0, 4'd0,  1'b1, 1'b0, 12'h001};
        tbl[8]  = '{1'b1, 8'h1C, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[9]  = '{1'b1, 8'hE0, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[10] = '{1'b1, 8'h1C, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[11] = '{1'b1, 8'hE0, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[12] = '{1'b1, 8'hF0, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[13] = '{1'b1, 8'h1C, 4'd0,  1'b0, 1'b0, 12'h000};
        tbl[14] = '{1'b1, 8'h1B, 4'd2,  1'b1, 1'b1, 12'h004};
        tbl[15] = '{1'b0, 8'h1B, 4'd2,  1'b1, 1'b0, 12'h004};
        repeat (2) @(negedge clk);
        do_reset();
        #1;
        chk_zero("reset");
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].stb, tbl[i].d);
            chk($sformatf("tbl%0d note", i), note_o[1], tbl[i].note);
            chk($sformatf("tbl%0d note_in", i), gate_o[1], tbl[i].gate);
            chk($sformatf("tbl%0d note_trig", i), trig_o[1], tbl[i].trig);
            chk($sformatf("tbl%0d held_mask", i), mask_o[1], tbl[i].mask);
        end
        // gate drops without fallback when the sounding key is released
        do_reset();
        cycle(1, 8'h1C); cycle(1, 8'h3B); cycle(1, 8'hF0); cycle(1, 8'h3B);
        chk("nofb gate", gate_o[0], 0);
        chk("fb gate", gate_o[1], 1);
        // typematic octave repeats
        do_reset();
        up_cnt = 0;
        repeat (4) cycle(1, 8'h22);
        cycle(1, 8'hF0); cycle(1, 8'h22); cycle(1, 8'h22); cycle(0, 8'h00);
        chk("octave up pulses", up_cnt, 2);
        // sustain holds the gate through a release
        do_reset();
        cycle(1, 8'h0D); cycle(1, 8'hF0); cycle(1, 8'h0D);
        cycle(1, 8'h23); cycle(1, 8'hF0); cycle(1, 8'h23);
        chk("sus note", note_o[1], 4);
        chk("sus gate held", gate_o[1], 1);
        cycle(1, 8'h0D);
        chk("sus cleared", sus_o[1], 0);
        chk("sus gate drop", gate_o[1], 0);
        // asynchronous mid-stream reset, strobe during reset ignored
        cycle(1, 8'h1C); cycle(1, 8'h24);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        ps2_key_pressed = 1'b1;
        ps2_key_data = 8'h22;
        @(posedge clk);
        #1;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
        reset = 1'b0;
        m[0] = '0;
        m[1] = '0;
        chk_zero("strobe in reset");
        cycle(1, 8'hF0); cycle(1, 8'h1C);
        chk("post reset mask", mask_o[1], 0);
        chk("post reset gate", gate_o[1], 0);
        // random stream against the model
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b;
            b = pool[$urandom_range(0, 19)];
            cycle($urandom_range(0, 3) != 0, b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
